// File: rtl/bcd_display_mux_if.sv
// Load/value input and display drive bundle for the multiplexed BCD display.
interface bcd_display_mux_if #(
  parameter int NDIGITS = 5
);
  logic                   load;
  logic [4*NDIGITS-1:0]   bcd;
  logic [6:0]             seg;
  logic [NDIGITS-1:0]     an;
  logic                   dp;
  logic                   err;

  modport master (output load, bcd, input seg, an, dp, err);
  modport slave  (input load, bcd, output seg, an, dp, err);
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits,
// with leading-zero blanking and a flag for non-decimal nibbles.
module bcd_display_mux #(
  parameter int NDIGITS     = 5,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_ZEROS = 1
) (
  input  logic             clk,
  input  logic             rst,
  bcd_display_mux_if.slave disp
);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NDIGITS - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]         SEG_BLANK = 7'h7F;
  localparam logic [NDIGITS-1:0] AN_OFF    = {NDIGITS{1'b1}};
  localparam logic [NDIGITS-1:0] AN_ONE    = NDIGITS'(1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic has_bad_nibble(input logic [4*NDIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // True when digit idx and every more-significant digit are zero.
  function automatic logic upper_zero(input logic [4*NDIGITS-1:0] v,
                                      input logic [IDX_W-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if ((i >= int'(idx)) && (v[4*i +: 4] != 4'd0)) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    return !nz;
  endfunction

  logic [4*NDIGITS-1:0] bcd_q,   bcd_d;
  logic                 valid_q, valid_d;
  logic                 err_q,   err_d;
  logic [DIV_W-1:0]     div_q,   div_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [6:0]           seg_q,   seg_d;
  logic [NDIGITS-1:0]   an_q,    an_d;
  logic                 dp_q,    dp_d;
  logic [3:0]           nib_s;
  logic                 blank_s;

  // Next-state: capture, prescaler/scan index, and the registered display drive.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = err_q;
    div_d   = div_q;
    idx_d   = idx_q;
    seg_d   = SEG_BLANK;
    an_d    = AN_OFF;
    dp_d    = 1'b1;

    if (disp.load) begin
      bcd_d   = disp.bcd;
      valid_d = 1'b1;
      err_d   = has_bad_nibble(disp.bcd);
    end else begin
      bcd_d   = bcd_q;
      valid_d = valid_q;
      err_d   = err_q;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end

    nib_s   = bcd_q[4*int'(idx_q) +: 4];
    blank_s = !valid_q ||
              ((BLANK_ZEROS != 0) && (idx_q != '0) && upper_zero(bcd_q, idx_q));

    // The anode pattern is derived from one index register, so it is one-hot-low by construction.
    if (blank_s) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end else begin
      seg_d = seg_decode(nib_s);
      an_d  = ~(AN_ONE << idx_q);
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
    end else begin
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.an  = an_q;
  assign disp.dp  = dp_q;
  assign disp.err = err_q;
endmodule
